// File: rtl/wd_pkg.sv
// Shared definitions for the watchdog escalation block: state encodings,
// default counter width and default system-reset pulse length.
package wd_pkg;

    localparam int CNT_W_DEF         = 4;
    localparam int RST_PULSE_LEN_DEF = 16;

    // Pulse counter width; covers the full 1..255 pulse-length range.
    localparam int PULSE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WARN    = 2'b01,
        ST_FAULT   = 2'b10,
        ST_RECOVER = 2'b11
    } wd_state_e;

endpackage

// File: rtl/wd_edge_det.sv
// Rising-edge detector for the frame-window overrun level. The history
// register resets to 0, so a level already high at reset release is seen
// as an edge on the first clock.
module wd_edge_det (
    input  logic CLK,
    input  logic WDRST,
    input  logic din,
    output logic rise
);

    logic din_q;

    // One-cycle history of the input level
    always_ff @(posedge CLK or posedge WDRST) begin
        if (WDRST) din_q <= 1'b0;
        else       din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/wd_escalation.sv
// Watchdog escalation: counts consecutive frame-window overruns, raises a
// sticky warning IRQ at WARN_THR misses and fires a fixed-length system
// reset pulse at FAULT_THR misses, then waits for the overrun level to clear.
module wd_escalation
    import wd_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int RST_PULSE_LEN = RST_PULSE_LEN_DEF
) (
    input  logic             CLK,
    input  logic             WDRST,
    input  logic             FW_OVR,
    input  logic             WDSRVC,
    input  logic [CNT_W-1:0] WARN_THR,
    input  logic [CNT_W-1:0] FAULT_THR,
    input  logic             IRQ_CLR,
    output logic             WD_IRQ,
    output logic             SYS_RST,
    output logic             FAULT_SEEN,
    output logic [CNT_W-1:0] FAIL_CNT,
    output logic [1:0]       STATE
);

    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [PULSE_W-1:0] PULSE_LEN = PULSE_W'(RST_PULSE_LEN);

    wd_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_upd;
    logic [PULSE_W-1:0] pulse_q, pulse_d;
    logic               irq_q, fseen_q, srst_q;
    logic               miss, srvc, warn_hit, fault_hit;
    logic               irq_set, fault_enter;

    wd_edge_det u_edge (
        .CLK   (CLK),
        .WDRST (WDRST),
        .din   (FW_OVR),
        .rise  (miss)
    );

    // A service only counts when no miss lands in the same cycle
    assign srvc = WDSRVC & ~miss;

    // Count as it would be after this edge; thresholds are compared against it
    always_comb begin
        cnt_upd = cnt_q;
        if (miss) begin
            if (cnt_q != CNT_MAX) cnt_upd = cnt_q + CNT_W'(1);
        end else if (srvc) begin
            cnt_upd = '0;
        end
    end

    assign warn_hit  = (WARN_THR  != '0) && (cnt_upd >= WARN_THR);
    assign fault_hit = (FAULT_THR != '0) && (cnt_upd >= FAULT_THR);

    // Next-state, miss counter and pulse counter
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_d     = pulse_q;
        irq_set     = 1'b0;
        fault_enter = 1'b0;
        case (state_q)
            ST_IDLE, ST_WARN: begin
                cnt_d = cnt_upd;
                if (fault_hit) begin
                    state_d     = ST_FAULT;
                    cnt_d       = '0;
                    pulse_d     = PULSE_LEN;
                    irq_set     = 1'b1;
                    fault_enter = 1'b1;
                end else if (state_q == ST_IDLE && warn_hit) begin
                    state_d = ST_WARN;
                    irq_set = 1'b1;
                end else if (state_q == ST_WARN && srvc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                // Misses and services are ignored while the pulse runs
                if (pulse_q <= PULSE_W'(1)) begin
                    state_d = ST_RECOVER;
                    pulse_d = '0;
                end else begin
                    pulse_d = pulse_q - PULSE_W'(1);
                end
            end
            ST_RECOVER: begin
                if (!FW_OVR) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and the registered reset pulse
    always_ff @(posedge CLK or posedge WDRST) begin
        if (WDRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= '0;
            srst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            srst_q  <= (state_d == ST_FAULT);
        end
    end

    // Sticky IRQ (set beats clear) and sticky fault flag
    always_ff @(posedge CLK or posedge WDRST) begin
        if (WDRST) begin
            irq_q   <= 1'b0;
            fseen_q <= 1'b0;
        end else begin
            if (irq_set)      irq_q <= 1'b1;
            else if (IRQ_CLR) irq_q <= 1'b0;
            if (fault_enter)  fseen_q <= 1'b1;
        end
    end

    assign WD_IRQ     = irq_q;
    assign SYS_RST    = srst_q;
    assign FAULT_SEEN = fseen_q;
    assign FAIL_CNT   = cnt_q;
    assign STATE      = state_q;

endmodule

// File: tb/tb_wd_escalation.sv
// Directed bench for wd_escalation: expected output snapshots are queued
// when stimulus is applied and popped/compared after the clock edge.
module tb_wd_escalation;

    logic       CLK = 1'b0;
    logic       WDRST, FW_OVR, WDSRVC, IRQ_CLR;
    logic [3:0] WARN_THR, FAULT_THR;
    logic       WD_IRQ, SYS_RST, FAULT_SEEN;
    logic [3:0] FAIL_CNT;
    logic [1:0] STATE;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [3:0] cnt;
        logic       irq;
        logic       srst;
        logic       fs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    wd_escalation #(.CNT_W(4), .RST_PULSE_LEN(16)) dut (
        .CLK        (CLK),
        .WDRST      (WDRST),
        .FW_OVR     (FW_OVR),
        .WDSRVC     (WDSRVC),
        .WARN_THR   (WARN_THR),
        .FAULT_THR  (FAULT_THR),
        .IRQ_CLR    (IRQ_CLR),
        .WD_IRQ     (WD_IRQ),
        .SYS_RST    (SYS_RST),
        .FAULT_SEEN (FAULT_SEEN),
        .FAIL_CNT   (FAIL_CNT),
        .STATE      (STATE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input logic [1:0] st, input logic [3:0] cnt,
                        input logic irq, input logic srst, input logic fs);
        exp_t e;
        e.tag = tag; e.st = st; e.cnt = cnt; e.irq = irq; e.srst = srst; e.fs = fs;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".STATE"},      8'(STATE),      8'(e.st));
            chk({e.tag, ".FAIL_CNT"},   8'(FAIL_CNT),   8'(e.cnt));
            chk({e.tag, ".WD_IRQ"},     8'(WD_IRQ),     8'(e.irq));
            chk({e.tag, ".SYS_RST"},    8'(SYS_RST),    8'(e.srst));
            chk({e.tag, ".FAULT_SEEN"}, 8'(FAULT_SEEN), 8'(e.fs));
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Queue the expectation, clock once, compare
    task automatic step(input string tag, input logic [1:0] st, input logic [3:0] cnt,
                        input logic irq, input logic srst, input logic fs);
        push(tag, st, cnt, irq, srst, fs);
        tick();
        compare();
    endtask

    initial begin
        WDRST = 1'b1; FW_OVR = 1'b0; WDSRVC = 1'b0; IRQ_CLR = 1'b0;
        WARN_THR = 4'd2; FAULT_THR = 4'd4;
        #12;
        push("reset", 2'b00, 4'd0, 0, 0, 0);
        compare();
        WDRST = 1'b0;
        step("idle", 2'b00, 4'd0, 0, 0, 0);

        // Two rising edges reach the warning threshold
        FW_OVR = 1; step("edge1", 2'b00, 4'd1, 0, 0, 0);
        FW_OVR = 0; step("edge1_lo", 2'b00, 4'd1, 0, 0, 0);
        FW_OVR = 1; step("edge2_warn", 2'b01, 4'd2, 1, 0, 0);
        FW_OVR = 0; step("warn_hold", 2'b01, 4'd2, 1, 0, 0);
        IRQ_CLR = 1; step("irq_clr", 2'b01, 4'd2, 0, 0, 0);
        IRQ_CLR = 0;

        // Service returns to IDLE; miss beats a same-cycle service
        WDSRVC = 1; step("srvc_warn_idle", 2'b00, 4'd0, 0, 0, 0);
        WDSRVC = 0; FW_OVR = 1; step("cnt_to_1", 2'b00, 4'd1, 0, 0, 0);
        FW_OVR = 0; step("cnt_1_hold", 2'b00, 4'd1, 0, 0, 0);
        FW_OVR = 1; WDSRVC = 1; step("miss_beats_srvc", 2'b01, 4'd2, 1, 0, 0);
        step("srvc_alone", 2'b00, 4'd0, 1, 0, 0);
        WDSRVC = 0; FW_OVR = 0; step("quiet", 2'b00, 4'd0, 1, 0, 0);

        // A held-high level counts once
        FW_OVR = 1; step("held_first", 2'b00, 4'd1, 1, 0, 0);
        for (int i = 1; i < 50; i++) tick();
        push("held_50", 2'b00, 4'd1, 1, 0, 0); compare();
        FW_OVR = 0; IRQ_CLR = 1; step("held_release", 2'b00, 4'd1, 0, 0, 0);

        // IRQ set wins over a same-cycle clear, then escalate to FAULT
        FW_OVR = 1; step("set_beats_clr", 2'b01, 4'd2, 1, 0, 0);
        IRQ_CLR = 0; FW_OVR = 0; tick();
        FW_OVR = 1; step("cnt3", 2'b01, 4'd3, 1, 0, 0);
        FW_OVR = 0; IRQ_CLR = 1; step("cnt3_clr", 2'b01, 4'd3, 0, 0, 0);
        IRQ_CLR = 0; FW_OVR = 1; step("fault_enter", 2'b10, 4'd0, 1, 1, 1);
        WDSRVC = 1;
        for (int i = 2; i <= 16; i++) begin
            FW_OVR = i[0];
            step($sformatf("pulse_c%0d", i), 2'b10, 4'd0, 1, 1, 1);
        end
        WDSRVC = 0; FW_OVR = 1;
        step("recover", 2'b11, 4'd0, 1, 0, 1);
        step("recover_hold", 2'b11, 4'd0, 1, 0, 1);
        FW_OVR = 0; step("recover_idle", 2'b00, 4'd0, 1, 0, 1);

        // Reset asserted in the fifth pulse cycle
        WARN_THR = 4'd0; FAULT_THR = 4'd1;
        FW_OVR = 1; step("fault2", 2'b10, 4'd0, 1, 1, 1);
        for (int i = 2; i <= 5; i++) step($sformatf("fault2_c%0d", i), 2'b10, 4'd0, 1, 1, 1);
        #2 WDRST = 1'b1;
        #1 push("async_rst", 2'b00, 4'd0, 0, 0, 0); compare();
        FW_OVR = 0;
        #2 WDRST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("no_residual_pulse", 8'(SYS_RST), 8'd0);
        end
        push("post_rst", 2'b00, 4'd0, 0, 0, 0); compare();

        // Level high at reset release counts once; then saturation
        FAULT_THR = 4'd0;
        #2 WDRST = 1'b1; FW_OVR = 1;
        #2 WDRST = 1'b0;
        step("release_miss", 2'b00, 4'd1, 0, 0, 0);
        for (int k = 2; k <= 20; k++) begin
            FW_OVR = 0; tick();
            FW_OVR = 1;
            step($sformatf("sat_%0d", k), 2'b00, (k > 15) ? 4'd15 : 4'(k), 0, 0, 0);
        end
        FW_OVR = 0; step("sat_final", 2'b00, 4'd15, 0, 0, 0);

        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Safety net: never hang
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
